// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage sequencer for a data memory with variable latency.
//
// The block takes the load/store held in the EX/MEM register and runs a
// req/ack handshake with data memory. It stalls every upstream stage until
// the access completes. It then hands the load data and a write-enable to
// the MEM/WB register. If the memory never answers, the access is abandoned
// after TIMEOUT request cycles, its writeback is killed and a sticky error
// is raised. Non-memory instructions pass through with no added latency.
//
// Parameters:
//   TIMEOUT  request cycles without dmem_ack before abort (1..2^TO_W-1)
//   TO_W     width of the timeout counter
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   ex_valid/ex_mem_read/ex_mem_write, ex_addr, ex_wdata
//                                  instruction held in EX/MEM
//   dmem_req/we/addr/wdata         registered request to data memory
//   dmem_ack, dmem_rdata           memory completion and read data
//   stall                          freeze PC, IF/ID, ID/EX, EX/MEM
//   wb_load, wb_kill               MEM/WB capture enable and bubble control
//   mem_data                       load data for MEM/WB
//   err                            sticky timeout flag, cleared by reset only
//
// Optional build macro MEM_STAGE_PERF_EN adds the output stall_cycles. It is
// a 32-bit saturating count of the cycles in which stall is asserted.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        wb_load,
  output logic        wb_kill,
  output logic [31:0] mem_data,
`ifdef MEM_STAGE_PERF_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          r_state;
  state_e          w_next;
  logic [TO_W-1:0] r_cnt;
  logic            r_kill;
  logic            w_memop;
  logic            w_timeout;

  assign w_memop   = ex_valid & (ex_mem_read | ex_mem_write);
  // The counter holds the number of REQ cycles already spent without an ack.
  // The TIMEOUT-th cycle is therefore the one that sees TIMEOUT-1.
  assign w_timeout = (r_cnt == TO_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking (<=) assignments so that every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so that no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    w_next  = r_state;
    stall   = 1'b0;
    wb_load = 1'b0;
    wb_kill = 1'b1;
    if (rst_n) begin
      unique case (r_state)
        IDLE: begin
          if (w_memop) begin
            stall  = 1'b1;
            w_next = REQ;
          end else begin
            wb_load = 1'b1;
            wb_kill = ~ex_valid;
          end
        end
        REQ: begin
          stall = 1'b1;
          if (dmem_ack || w_timeout) w_next = RESP;
        end
        RESP: begin
          wb_load = 1'b1;
          wb_kill = r_kill;
          w_next  = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // Request, data and status registers. A store wins when read and write
  // are both set: dmem_we stays 1, so mem_data is left untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      mem_data   <= '0;
      err        <= 1'b0;
      r_cnt      <= '0;
      r_kill     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_memop) begin
            dmem_req   <= 1'b1;
            dmem_we    <= ex_mem_write;
            dmem_addr  <= ex_addr;
            dmem_wdata <= ex_wdata;
            r_cnt      <= '0;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            // An ack on the final allowed cycle still counts as success.
            dmem_req <= 1'b0;
            r_kill   <= 1'b0;
            if (!dmem_we) mem_data <= dmem_rdata;
          end else if (w_timeout) begin
            dmem_req <= 1'b0;
            err      <= 1'b1;
            mem_data <= '0;
            r_kill   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                             stall_cycles <= '0;
    else if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule
